// File: rtl/ofmaps_bit_writer.sv
// Packs tagged single-bit activations into DATA_WIDTH-bit ofmaps BRAM words and writes
// them through a bit-masked port; flushes the partial word and pulses layer_done on i_last.
module ofmaps_bit_writer #(
   parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH             = 32,
   parameter int SEL_W                  = $clog2(DATA_WIDTH),
   parameter int WADDR_W                = OFMAPS_BRAM_ADDR_WIDTH - SEL_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_data,
   input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] address_in,
   input  logic                              i_valid,
   input  logic                              i_last,
   output logic                              bram_en,
   output logic [DATA_WIDTH-1:0]             bram_we,
   output logic [WADDR_W-1:0]                bram_addr,
   output logic [DATA_WIDTH-1:0]             bram_din,
   output logic                              layer_done,
   output logic [15:0]                       words_written,
   output logic                              o_overrun
);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_e;

   state_e                  state_q, state_d;
   logic                    buf_vld_q, buf_vld_d;
   logic [DATA_WIDTH-1:0]   buf_mask_q, buf_mask_d;
   logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
   logic [WADDR_W-1:0]      buf_addr_q, buf_addr_d;

   logic                    wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]   wr_mask_q, wr_mask_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [WADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;
   logic [15:0]             words_q, words_d;

   logic [SEL_W-1:0]        bit_sel;
   logic [WADDR_W-1:0]      word_addr;
   logic [DATA_WIDTH-1:0]   bit_oh;
   logic                    same_word;
   logic [DATA_WIDTH-1:0]   merged_mask;
   logic [DATA_WIDTH-1:0]   merged_data;

   assign bit_sel     = address_in[SEL_W-1:0];
   assign word_addr   = address_in[OFMAPS_BRAM_ADDR_WIDTH-1:SEL_W];
   assign bit_oh      = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_sel;
   assign same_word   = buf_vld_q && (word_addr == buf_addr_q);
   // A bit landing in an empty or different word starts from a clean buffer.
   assign merged_mask = (same_word ? buf_mask_q : '0) | bit_oh;
   assign merged_data = ((same_word ? buf_data_q : '0) & ~bit_oh) | (i_data ? bit_oh : '0);

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
      state_d    = state_q;
      buf_vld_d  = buf_vld_q;
      buf_mask_d = buf_mask_q;
      buf_data_d = buf_data_q;
      buf_addr_d = buf_addr_q;
      wr_en_d    = 1'b0;
      wr_mask_d  = '0;
      wr_data_d  = '0;
      wr_addr_d  = '0;
      done_d     = 1'b0;
      overrun_d  = overrun_q;

      case (state_q)
         ST_RUN: begin
            if (i_valid) begin
               if (buf_vld_q && !same_word) begin
                  wr_en_d    = 1'b1;
                  wr_mask_d  = buf_mask_q;
                  wr_data_d  = buf_data_q;
                  wr_addr_d  = buf_addr_q;
                  buf_vld_d  = 1'b1;
                  buf_mask_d = bit_oh;
                  buf_data_d = i_data ? bit_oh : '0;
                  buf_addr_d = word_addr;
               end else if (&merged_mask) begin
                  wr_en_d    = 1'b1;
                  wr_mask_d  = merged_mask;
                  wr_data_d  = merged_data;
                  wr_addr_d  = word_addr;
                  buf_vld_d  = 1'b0;
                  buf_mask_d = '0;
                  buf_data_d = '0;
                  buf_addr_d = '0;
               end else begin
                  buf_vld_d  = 1'b1;
                  buf_mask_d = merged_mask;
                  buf_data_d = merged_data;
                  buf_addr_d = word_addr;
               end
            end
            if (i_last) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (buf_vld_q) begin
               wr_en_d   = 1'b1;
               wr_mask_d = buf_mask_q;
               wr_data_d = buf_data_q;
               wr_addr_d = buf_addr_q;
            end
            buf_vld_d  = 1'b0;
            buf_mask_d = '0;
            buf_data_d = '0;
            buf_addr_d = '0;
            done_d     = 1'b1;
            if (i_valid) overrun_d = 1'b1;
            state_d    = ST_DONE;
         end
         default: begin
            if (i_valid) overrun_d = 1'b1;
            state_d = ST_RUN;
         end
      endcase

      words_d = (wr_en_d && (words_q != 16'hFFFF)) ? words_q + 16'd1 : words_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q    <= ST_RUN;
         buf_vld_q  <= 1'b0;
         buf_mask_q <= '0;
         buf_data_q <= '0;
         buf_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wr_mask_q  <= '0;
         wr_data_q  <= '0;
         wr_addr_q  <= '0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         buf_vld_q  <= buf_vld_d;
         buf_mask_q <= buf_mask_d;
         buf_data_q <= buf_data_d;
         buf_addr_q <= buf_addr_d;
         wr_en_q    <= wr_en_d;
         wr_mask_q  <= wr_mask_d;
         wr_data_q  <= wr_data_d;
         wr_addr_q  <= wr_addr_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
         words_q    <= words_d;
      end
   end

   assign bram_en       = wr_en_q;
   assign bram_we       = wr_mask_q;
   assign bram_din      = wr_data_q;
   assign bram_addr     = wr_addr_q;
   assign layer_done    = done_q;
   assign words_written = words_q;
   assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_ofmaps_bit_writer.sv
// Scoreboard bench for ofmaps_bit_writer: a bit-level reference model predicts every BRAM
// write and layer_done pulse with its cycle; a negedge monitor pops and compares them.
module tb_ofmaps_bit_writer;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int WW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_data;
   logic [AW-1:0] address_in;
   logic          i_valid;
   logic          i_last;
   logic          bram_en;
   logic [DW-1:0] bram_we;
   logic [WW-1:0] bram_addr;
   logic [DW-1:0] bram_din;
   logic          layer_done;
   logic [15:0]   words_written;
   logic          o_overrun;

   always #5 clk = ~clk;

   ofmaps_bit_writer dut (
      .clk(clk), .rst(rst), .i_data(i_data), .address_in(address_in),
      .i_valid(i_valid), .i_last(i_last), .bram_en(bram_en), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_din(bram_din), .layer_done(layer_done),
      .words_written(words_written), .o_overrun(o_overrun)
   );

   typedef struct {
      logic [WW-1:0] addr;
      logic [DW-1:0] we;
      logic [DW-1:0] din;
      int            cyc;
   } wr_t;

   wr_t wr_q[$];
   int  done_q[$];
   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;

   // Reference model: the open word and each of its bits (-1 = not yet received).
   int  cur_word = -1;
   int  bitv[DW];
   int  mode = 0;
   bit  m_overrun = 1'b0;
   int  m_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [95:0] act, logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void clear_bits();
      for (int i = 0; i < DW; i++) bitv[i] = -1;
      cur_word = -1;
   endfunction

   function automatic void push_write(int e);
      wr_t w;
      w.addr = cur_word[WW-1:0];
      w.we   = '0;
      w.din  = '0;
      for (int i = 0; i < DW; i++) begin
         if (bitv[i] >= 0) w.we[i] = 1'b1;
         if (bitv[i] == 1) w.din[i] = 1'b1;
      end
      w.cyc = e;
      wr_q.push_back(w);
      if (m_count < 65535) m_count++;
   endfunction

   // Drive one cycle of inputs at a negedge and advance the model by that sampling edge.
   task automatic step(bit r, bit v, bit d, int a, bit l);
      int  e;
      int  w;
      int  s;
      bit  full;
      e          = cyc + 1;
      rst        = r;
      i_valid    = v;
      i_data     = d;
      address_in = a[AW-1:0];
      i_last     = l;
      if (r) begin
         clear_bits();
         mode      = 0;
         m_overrun = 1'b0;
         m_count   = 0;
      end else if (mode == 0) begin
         if (v) begin
            w = (a % 4096) / DW;
            s = a % DW;
            if (cur_word >= 0 && cur_word != w) begin
               push_write(e);
               clear_bits();
            end
            cur_word = w;
            bitv[s]  = d ? 1 : 0;
            full = 1'b1;
            for (int i = 0; i < DW; i++) if (bitv[i] < 0) full = 1'b0;
            if (full) begin
               push_write(e);
               clear_bits();
            end
         end
         if (l) mode = 1;
      end else if (mode == 1) begin
         if (cur_word >= 0) push_write(e);
         clear_bits();
         done_q.push_back(e);
         if (v) m_overrun = 1'b1;
         mode = 2;
      end else begin
         if (v) m_overrun = 1'b1;
         mode = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("reset_outputs",
            {bram_en, bram_we, bram_addr, bram_din, layer_done, words_written, o_overrun},
            '0);
   endtask

   task automatic checkpoint(string name);
      check({name, "_words"}, words_written, m_count);
      check({name, "_overrun"}, o_overrun, m_overrun);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bram_en) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", {95'b0, bram_en}, '0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               check("write_word", {bram_addr, bram_we, bram_din}, {w.addr, w.we, w.din});
               check("write_cycle", cyc, w.cyc);
            end
         end
         if (layer_done) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", {95'b0, layer_done}, '0);
            end else begin
               int dc;
               dc = done_q.pop_front();
               check("done_cycle", cyc, dc);
            end
         end
      end
   end

   initial begin
      int seq;
      int a;
      rst = 1'b1; i_valid = 1'b0; i_data = 1'b0; address_in = '0; i_last = 1'b0;
      clear_bits();
      @(negedge clk);
      do_reset();
      mon_en = 1'b1;

      // Full sequential word: one write, din alternating from data=addr[0].
      for (int i = 0; i < 32; i++) step(0, 1, i[0], i, 0);
      idle(3);
      checkpoint("full_word");

      // Word change writes the partial word, then i_last flushes the remainder.
      do_reset();
      step(0, 1, 1, 5, 0);
      step(0, 1, 1, 6, 0);
      step(0, 1, 1, 40, 0);
      step(0, 0, 0, 0, 1);
      idle(3);
      checkpoint("word_change_flush");

      // i_valid together with i_last: bit taken then flushed, no overrun.
      step(0, 1, 1, 70, 1);
      idle(3);
      checkpoint("valid_with_last");

      // i_valid in the FLUSH cycle is dropped and sets the sticky overrun.
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 100, 0);
      idle(3);
      checkpoint("overrun_set");
      idle(5);
      checkpoint("overrun_sticky");

      // Mid-word reset discards the buffer; then a repeated bit_sel overwrites.
      for (int i = 0; i < 10; i++) step(0, 1, 1, 128 + i, 0);
      do_reset();
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 3, 0);
      step(0, 1, 1, 7, 0);
      step(0, 0, 0, 0, 1);
      idle(3);
      checkpoint("overwrite_after_reset");

      // Randomized: sequential runs and scattered addresses, occasional i_last.
      seq = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            a   = seq;
            seq = (seq + 1) % 4096;
         end else begin
            a = $urandom_range(0, 3) * DW + $urandom_range(0, DW - 1);
         end
         step(0, $urandom_range(0, 4) != 0, $urandom_range(0, 1), a, $urandom_range(0, 60) == 0);
         if (i % 500 == 499) checkpoint("random");
      end
      step(0, 0, 0, 0, 1);
      idle(5);
      checkpoint("random_end");
      check("pending_writes", wr_q.size(), 0);
      check("pending_dones", done_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
